ex_muldiv_unit: RTL and testbench

//  Execute-stage multiply/divide unit owning the HI/LO registers. Sits beside the ALU
//  in EX, feeding the EX/ME pipeline register via hi/lo (for MFHI/MFLO).

---
 rtl/md_pkg.sv | 31 +++
 rtl/md_latency_timer.sv | 37 +++
 rtl/ex_muldiv_unit.sv | 124 ++++++++++++
 tb/tb_ex_muldiv_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared multiply/divide encodings, default latencies and the start-class
// helper used by decode, the hazard unit and the EX-stage MD unit.
package md_pkg;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  localparam int unsigned MUL_LAT_DEFAULT = 5;
  localparam int unsigned DIV_LAT_DEFAULT = 10;

  // Result captured at start and committed to HI/LO when the timer expires.
  typedef struct packed {
    logic        wr;
    logic [31:0] hi;
    logic [31:0] lo;
  } md_result_t;

  function automatic logic is_md_start(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_md_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_latency_timer.sv
// 4-bit busy countdown: load starts a run of load_val busy cycles and
// done_pulse marks the final busy cycle, whose closing edge commits the result.
module md_latency_timer
  import md_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       busy,
  output logic       done_pulse
);

  logic [3:0] count_q;
  logic [3:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != 4'd0) begin
      count_d = count_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign busy       = (count_q != 4'd0);
  assign done_pulse = (count_q == 4'd1);

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage multiply/divide unit owning HI/LO. The result is computed
// combinationally at start, held, and committed when the latency timer expires.
module ex_muldiv_unit
  import md_pkg::*;
#(
  parameter int unsigned MUL_LAT = MUL_LAT_DEFAULT,
  parameter int unsigned DIV_LAT = DIV_LAT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic        done_pulse;
  logic [3:0]  lat_val;

  logic [63:0] a_sx;
  logic [63:0] b_sx;
  logic [63:0] prod_s;
  logic [63:0] prod_u;

  logic        div_signed;
  logic        a_neg;
  logic        b_neg;
  logic        b_zero;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quot_mag;
  logic [31:0] rem_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  md_result_t  calc;
  md_result_t  res_q;
  md_result_t  res_d;
  logic [31:0] hi_q;
  logic [31:0] hi_d;
  logic [31:0] lo_q;
  logic [31:0] lo_d;

  assign start   = is_md_start(md_op) && !busy;
  assign lat_val = is_md_div(md_op) ? 4'(DIV_LAT) : 4'(MUL_LAT);

  md_latency_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (start),
    .load_val   (lat_val),
    .busy       (busy),
    .done_pulse (done_pulse)
  );

  // The low 64 bits of a sign-extended 64x64 product equal the signed 32x32 product.
  assign a_sx   = {{32{src_a[31]}}, src_a};
  assign b_sx   = {{32{src_b[31]}}, src_b};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, src_a} * {32'd0, src_b};

  // One unsigned divider serves both DIV and DIVU via sign-magnitude; this also
  // gives 0x80000000 / -1 = 0x80000000 without any overflow trap.
  assign div_signed = (md_op == MD_DIV);
  assign a_neg      = div_signed && src_a[31];
  assign b_neg      = div_signed && src_b[31];
  assign b_zero     = (src_b == 32'd0);
  assign dividend   = a_neg ? (32'd0 - src_a) : src_a;
  assign divisor    = b_zero ? 32'd1 : (b_neg ? (32'd0 - src_b) : src_b);
  assign quot_mag   = dividend / divisor;
  assign rem_mag    = dividend % divisor;
  assign quot       = (a_neg ^ b_neg) ? (32'd0 - quot_mag) : quot_mag;
  assign rem        = a_neg ? (32'd0 - rem_mag) : rem_mag;

  always_comb begin
    calc = '0;
    case (md_op)
      MD_MULT:  calc = '{wr: 1'b1, hi: prod_s[63:32], lo: prod_s[31:0]};
      MD_MULTU: calc = '{wr: 1'b1, hi: prod_u[63:32], lo: prod_u[31:0]};
      MD_DIV,
      MD_DIVU:  calc = '{wr: !b_zero, hi: rem, lo: quot};
      default:  calc = '0;
    endcase
  end

  // HI/LO commit and MTHI/MTLO never coincide: commit needs busy, MT* needs !busy.
  always_comb begin
    res_d = start ? calc : res_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    if (done_pulse) begin
      if (res_q.wr) begin
        hi_d = res_q.hi;
        lo_d = res_q.lo;
      end
    end else if (!busy) begin
      if (md_op == MD_MTHI) begin
        hi_d = src_a;
      end
      if (md_op == MD_MTLO) begin
        lo_d = src_a;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      res_q <= '0;
      hi_q  <= 32'd0;
      lo_q  <= 32'd0;
    end else begin
      res_q <= res_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed corner cases followed by
// random op sequences, compared against a plain-arithmetic HI/LO model.
module tb_ex_muldiv_unit;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        start;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int          nCompared = 0;
  int          nMismatch = 0;
  int          protViol  = 0;
  logic [31:0] expHi     = 32'd0;
  logic [31:0] expLo     = 32'd0;

  ex_muldiv_unit #(.MUL_LAT(5), .DIV_LAT(10)) dut (
    .clk   (clk),
    .reset (reset),
    .md_op (md_op),
    .src_a (src_a),
    .src_b (src_b),
    .start (start),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  // Any MD instruction presented while busy breaks the hazard-unit contract.
  always @(posedge clk) begin
    if (!reset && busy && (md_op >= 3'd1) && (md_op <= 3'd6)) begin
      protViol <= protViol + 1;
      $display("[TB] protocol violation: op %0d presented while busy", md_op);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatch++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    md_op = op;
    src_a = a;
    src_b = b;
    #1;
  endtask

  function automatic int latencyOf(input logic [2:0] op);
    return (op == MD_DIV || op == MD_DIVU) ? 10 : 5;
  endfunction

  // Architectural result from the instruction definitions, using 64-bit integers.
  task automatic refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output bit wr, output logic [31:0] h, output logic [31:0] l);
    longint          sa, sb, sp, sq, sr;
    longint unsigned up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    wr = 1'b1;
    h  = 32'd0;
    l  = 32'd0;
    case (op)
      MD_MULT: begin
        sp = sa * sb;
        h  = 32'(sp >>> 32);
        l  = 32'(sp);
      end
      MD_MULTU: begin
        up = longint'(a) * longint'(b);
        h  = 32'(up >> 32);
        l  = 32'(up);
      end
      MD_DIV: begin
        if (b == 32'd0) wr = 1'b0;
        else begin
          sq = sa / sb;
          sr = sa % sb;
          l  = 32'(sq);
          h  = 32'(sr);
        end
      end
      MD_DIVU: begin
        if (b == 32'd0) wr = 1'b0;
        else begin
          l = a / b;
          h = a % b;
        end
      end
      default: wr = 1'b0;
    endcase
  endtask

  // Issue one op in the current (non-busy) cycle and follow it to completion.
  task automatic runOp(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit intrude);
    bit          wr;
    logic [31:0] h, l;
    int          lat;
    applyStimulus(op, a, b);
    checkOutput({tag, " start"}, 32'(start), 32'(is_md_start(op)));
    if (is_md_start(op)) begin
      refModel(op, a, b, wr, h, l);
      lat = latencyOf(op);
      tick();
      md_op = MD_NONE;
      for (int i = 0; i < lat; i++) begin
        checkOutput({tag, " busy"}, 32'(busy), 32'd1);
        if (intrude && i == 2) begin
          applyStimulus(MD_MULT, $urandom, $urandom);
          checkOutput({tag, " start while busy"}, 32'(start), 32'd0);
        end
        if (i == lat - 1) begin
          checkOutput({tag, " hi held"}, hi, expHi);
          checkOutput({tag, " lo held"}, lo, expLo);
        end
        tick();
        md_op = MD_NONE;
      end
      if (wr) begin
        expHi = h;
        expLo = l;
      end
    end else begin
      tick();
      md_op = MD_NONE;
      if (op == MD_MTHI) expHi = a;
      if (op == MD_MTLO) expLo = a;
    end
    checkOutput({tag, " busy done"}, 32'(busy), 32'd0);
    checkOutput({tag, " hi"}, hi, expHi);
    checkOutput({tag, " lo"}, lo, expLo);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    reset = 1'b1;
    md_op = MD_NONE;
    src_a = 32'd0;
    src_b = 32'd0;
    tick();
    tick();
    reset = 1'b0;
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset hi", hi, 32'd0);
    checkOutput("reset lo", lo, 32'd0);

    runOp("mult -2*3", MD_MULT, 32'hFFFFFFFE, 32'd3, 1'b0);
    checkOutput("mult hi const", hi, 32'hFFFFFFFF);
    checkOutput("mult lo const", lo, 32'hFFFFFFFA);
    runOp("multu max", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    checkOutput("multu hi const", hi, 32'hFFFFFFFE);
    checkOutput("multu lo const", lo, 32'h00000001);
    runOp("div -7/2", MD_DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
    checkOutput("div lo const", lo, 32'hFFFFFFFD);
    checkOutput("div hi const", hi, 32'hFFFFFFFF);
    runOp("divu by zero", MD_DIVU, 32'd7, 32'd0, 1'b0);
    checkOutput("divu0 hi kept", hi, 32'hFFFFFFFF);
    runOp("mthi", MD_MTHI, 32'h12345678, 32'd0, 1'b0);
    runOp("mtlo", MD_MTLO, 32'hCAFEBABE, 32'd0, 1'b0);
    checkOutput("mt hi const", hi, 32'h12345678);
    checkOutput("mt lo const", lo, 32'hCAFEBABE);
    runOp("div overflow", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    checkOutput("ovf lo const", lo, 32'h80000000);
    checkOutput("ovf hi const", hi, 32'h00000000);

    runOp("mult intruded", MD_MULT, 32'd6, 32'd7, 1'b1);
    runOp("divu back2back", MD_DIVU, 32'd100, 32'd7, 1'b0);
    checkOutput("b2b lo const", lo, 32'd14);
    checkOutput("b2b hi const", hi, 32'd2);
    checkOutput("protocol violations", 32'(protViol), 32'd1);

    // Reset in the second busy cycle of a DIV discards the in-flight op.
    runOp("mthi pre-reset", MD_MTHI, 32'h0000BEEF, 32'd0, 1'b0);
    applyStimulus(MD_DIV, 32'hFFFFFFF9, 32'd2);
    tick();
    md_op = MD_NONE;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expHi = 32'd0;
    expLo = 32'd0;
    checkOutput("midop reset busy", 32'(busy), 32'd0);
    checkOutput("midop reset hi", hi, 32'd0);
    checkOutput("midop reset lo", lo, 32'd0);
    for (int i = 0; i < 12; i++) tick();
    checkOutput("discarded busy", 32'(busy), 32'd0);
    checkOutput("discarded hi", hi, 32'd0);
    checkOutput("discarded lo", lo, 32'd0);

    for (int n = 0; n < 30; n++) begin
      rop = 3'($urandom_range(1, 6));
      ra  = $urandom;
      rb  = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        ra = $urandom_range(0, 5000);
        rb = $urandom_range(0, 40);
      end
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      runOp("random", rop, ra, rb, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
